// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl shared definitions: register offsets, CTRL/STATUS bit
// positions, bus direction codes, FSM state codes, FSM->regs events.
package dma_ctrl_pkg;

    localparam logic [1:0] DMA_CTRL = 2'd0;
    localparam logic [1:0] DMA_SRC  = 2'd1;
    localparam logic [1:0] DMA_DST  = 2'd2;
    localparam logic [1:0] DMA_LEN  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_ABORT = 2;

    localparam int STAT_BUSY = 31;
    localparam int STAT_DONE = 30;

    localparam logic READ    = 1'b1;
    localparam logic WRITE   = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_RD_AS   = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_AS   = 3'd4;
    localparam logic [2:0] ST_WR_WAIT = 3'd5;
    localparam logic [2:0] ST_GAP     = 3'd6;

    // Events from the master FSM into the register file.
    typedef struct packed {
        logic busy;      // engine not in IDLE
        logic adv;       // word finished: SRC+1, DST+1, LEN-1
        logic done_set;  // transfer finished or aborted
    } fsm_evt_t;

endpackage

// File: rtl/dma_ctrl_if.sv
// Bus bundles for dma_ctrl.
// dma_slv_if: CPU register port (master = CPU, slave = DMA).
// dma_mst_if: DMA bus-master port (master = DMA, slave = bus fabric).
interface dma_slv_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );
    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );
endinterface

interface dma_mst_if;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );
    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/dma_ctrl_regs.sv
// dma_ctrl register file: slave decode, CTRL/SRC/DST/LEN/STATUS, rdy_ timing.
// Ports: clk, reset_ (sync, active-low), slv (register port), evt (FSM
// events), start/abort pulses, live src/dst/len, irq. DMA_IRQ_EN adds IE.
module dma_ctrl_regs
    import dma_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_,
    dma_slv_if.slave         slv,
    input  fsm_evt_t         evt,
    output logic             start,
    output logic             abort,
    output logic [29:0]      src,
    output logic [29:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             irq
);

    logic             req_q, req_d;
    logic             rw_q, rw_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic             rdy_q, rdy_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [29:0]      src_q, src_d;
    logic [29:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             ie;
    logic             wr_en, rd_en;
    logic             wr_ctrl, wr_src, wr_dst, wr_len;
    logic [31:0]      stat, ctrl_rd;
    logic             unused_wdat;

    // Capture a request at edge N; it is serviced at edge N+1. New requests
    // are blocked while one is pending or rdy_ is low, so a strobe held
    // until rdy_ is seen is not taken twice.
    always_comb begin
        req_d  = 1'b0;
        rw_d   = rw_q;
        addr_d = addr_q;
        wdat_d = wdat_q;
        if (!slv.cs_ && !slv.as_ && !req_q && rdy_q) begin
            req_d  = 1'b1;
            rw_d   = slv.rw;
            addr_d = slv.addr;
            wdat_d = slv.wr_data;
        end
    end

    assign wr_en   = req_q && (rw_q == WRITE);
    assign rd_en   = req_q && (rw_q == READ);
    assign wr_ctrl = wr_en && (addr_q == DMA_CTRL);
    assign wr_src  = wr_en && (addr_q == DMA_SRC);
    assign wr_dst  = wr_en && (addr_q == DMA_DST);
    assign wr_len  = wr_en && (addr_q == DMA_LEN);
    assign start   = wr_ctrl && wdat_q[CTRL_START];
    assign abort   = wr_ctrl && wdat_q[CTRL_ABORT];

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        done_d = done_q;
        if (wr_src && !evt.busy) begin
            src_d = wdat_q[29:0];
        end else if (evt.adv) begin
            src_d = src_q + 30'd1;
        end
        if (wr_dst && !evt.busy) begin
            dst_d = wdat_q[29:0];
        end else if (evt.adv) begin
            dst_d = dst_q + 30'd1;
        end
        if (wr_len && !evt.busy) begin
            len_d = wdat_q[LEN_W-1:0];
        end else if (evt.adv && (len_q != '0)) begin
            len_d = len_q - LEN_W'(1);
        end
        // A completing transfer outranks a same-cycle clear.
        if (evt.done_set) begin
            done_d = 1'b1;
        end else if (wr_len) begin
            done_d = 1'b0;
        end
    end

`ifdef DMA_IRQ_EN
    logic ie_q, ie_d;

    always_comb begin
        ie_d = ie_q;
        if (wr_ctrl) begin
            ie_d = wdat_q[CTRL_IE];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            ie_q <= 1'b0;
        end else begin
            ie_q <= ie_d;
        end
    end

    assign ie          = ie_q;
    assign irq         = done_q & ie_q;
    assign unused_wdat = ^wdat_q[31:30];
`else
    assign ie          = DISABLE;
    assign irq         = DISABLE;
    assign unused_wdat = ^{wdat_q[31:30], wdat_q[CTRL_IE]};
`endif

    always_comb begin
        stat              = '0;
        stat[LEN_W-1:0]   = len_q;
        stat[STAT_BUSY]   = evt.busy;
        stat[STAT_DONE]   = done_q;
        ctrl_rd           = '0;
        ctrl_rd[CTRL_IE]  = ie;
        rd_data_d         = '0;
        if (rd_en) begin
            unique case (addr_q)
                DMA_CTRL: rd_data_d = ctrl_rd;
                DMA_SRC:  rd_data_d = {2'b00, src_q};
                DMA_DST:  rd_data_d = {2'b00, dst_q};
                DMA_LEN:  rd_data_d = stat;
            endcase
        end
        rdy_d = !req_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            req_q     <= 1'b0;
            rw_q      <= READ;
            addr_q    <= '0;
            wdat_q    <= '0;
            rdy_q     <= 1'b1;
            rd_data_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            req_q     <= req_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            done_q    <= done_d;
        end
    end

    assign slv.rdy_    = rdy_q;
    assign slv.rd_data = rd_data_q;
    assign src         = src_q;
    assign dst         = dst_q;
    assign len         = len_q;

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel word-copy DMA, master FSM + register sub-block.
// Ports: clk, reset_ (sync, active-low), slv (CPU registers), mst (bus
// master), irq (DONE & IE, level; tied low unless DMA_IRQ_EN is defined).
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic       clk,
    input  logic       reset_,
    dma_slv_if.slave   slv,
    dma_mst_if.master  mst,
    output logic       irq
);

    logic [2:0]       state_q, state_d;
    logic             abort_q, abort_d;
    logic [31:0]      data_q, data_d;
    fsm_evt_t         evt;
    logic             start, abort;
    logic [29:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             abort_any;
    logic             rd_ph, wr_ph;

    dma_ctrl_regs #(
        .LEN_W (LEN_W)
    ) u_regs (
        .clk    (clk),
        .reset_ (reset_),
        .slv    (slv),
        .evt    (evt),
        .start  (start),
        .abort  (abort),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .irq    (irq)
    );

    assign abort_any = abort_q | abort;

    // Abort is honoured only where no word is in flight (REQ, GAP), so a
    // word whose read has started always gets its write.
    always_comb begin
        state_d      = state_q;
        abort_d      = abort_any;
        data_d       = data_q;
        evt          = '0;
        evt.busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    if (len == '0) begin
                        evt.done_set = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (abort_any) begin
                    state_d      = ST_IDLE;
                    abort_d      = 1'b0;
                    evt.done_set = 1'b1;
                end else if (!mst.bus_grnt_) begin
                    state_d = ST_RD_AS;
                end
            end
            ST_RD_AS: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (!mst.bus_rdy_) begin
                    data_d  = mst.bus_rd_data;
                    state_d = ST_WR_AS;
                end
            end
            ST_WR_AS: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (!mst.bus_rdy_) begin
                    evt.adv = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if ((len == '0) || abort_any) begin
                    state_d      = ST_IDLE;
                    abort_d      = 1'b0;
                    evt.done_set = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            data_q  <= data_d;
        end
    end

    assign rd_ph = (state_q == ST_RD_AS) || (state_q == ST_RD_WAIT);
    assign wr_ph = (state_q == ST_WR_AS) || (state_q == ST_WR_WAIT);

    assign mst.bus_req_    = !(rd_ph || wr_ph || (state_q == ST_REQ));
    assign mst.bus_as_     = !((state_q == ST_RD_AS) ||
                               (state_q == ST_WR_AS));
    assign mst.bus_rw      = wr_ph ? WRITE : READ;
    assign mst.bus_addr    = rd_ph ? src : (wr_ph ? dst : '0);
    assign mst.bus_wr_data = wr_ph ? data_q : '0;

endmodule
